// File: rtl/debug_pkg.sv
// Shared definitions for the debugger command path.
// Holds the FN_* command codes, the NAK reply word, the decoder state
// encoding and the command classification helpers. controller_fsm imports
// the same codes so both ends agree on the command set.
package debug_pkg;

   localparam logic [3:0] FN_NONE        = 4'h0;
   localparam logic [3:0] FN_PAUSE       = 4'h1;
   localparam logic [3:0] FN_RESUME      = 4'h2;
   localparam logic [3:0] FN_STEP        = 4'h3;
   localparam logic [3:0] FN_RESET       = 4'h4;
   localparam logic [3:0] FN_STATUS      = 4'h5;
   localparam logic [3:0] FN_REG_RD      = 4'h6;
   localparam logic [3:0] FN_MEM_RD_WORD = 4'h7;
   localparam logic [3:0] FN_MEM_RD_BYTE = 4'h8;
   localparam logic [3:0] FN_BKPT_SET    = 4'h9;
   localparam logic [3:0] FN_BKPT_CLR    = 4'hA;
   localparam logic [3:0] FN_MEM_WR_WORD = 4'hB;
   localparam logic [3:0] FN_MEM_WR_BYTE = 4'hC;
   localparam logic [3:0] FN_REG_WR      = 4'hD;

   localparam logic [31:0] NAK_WORD = 32'hFFFF_FFFF;

   typedef enum logic [2:0] {
      S_CMD,
      S_ADDR,
      S_DATA,
      S_ISSUE,
      S_WAIT,
      S_REPLY,
      S_TXW
   } state_t;

   // Commands 6..D carry an address word.
   function automatic logic needs_addr(input logic [3:0] code);
      return (code >= FN_REG_RD) && (code <= FN_REG_WR);
   endfunction

   // Commands B..D additionally carry a data word.
   function automatic logic needs_data(input logic [3:0] code);
      return (code >= FN_MEM_WR_WORD) && (code <= FN_REG_WR);
   endfunction

   // Commands 5..8 reply with the controller's rd_data.
   function automatic logic is_read(input logic [3:0] code);
      return (code >= FN_STATUS) && (code <= FN_MEM_RD_BYTE);
   endfunction

   // 0, E and F are not real commands and are answered with NAK.
   function automatic logic is_valid_cmd(input logic [3:0] code);
      return (code != FN_NONE) && (code <= FN_REG_WR);
   endfunction

endpackage

// File: rtl/serial_cmd_decoder_if.sv
// Bundle of the decoder's UART-side and controller-side signals.
//   rx_data/rx_valid   : received byte strobe from UART rx
//   tx_data/tx_start   : byte strobe to UART tx, tx_busy back-pressure
//   cmd/addr/d_in      : command to controller, in_valid strobe
//   ctrlr_busy/rd_data : controller status and read data
//   rx_drop            : pulse when a received byte is discarded
// modport master is the decoder's view; modport slave is its environment.
interface serial_cmd_decoder_if;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic [7:0]  tx_data;
   logic        tx_start;
   logic        tx_busy;
   logic [3:0]  cmd;
   logic [31:0] addr;
   logic [31:0] d_in;
   logic        in_valid;
   logic        ctrlr_busy;
   logic [31:0] rd_data;
   logic        rx_drop;

   modport master (
      input  rx_data, rx_valid, tx_busy, ctrlr_busy, rd_data,
      output tx_data, tx_start, cmd, addr, d_in, in_valid, rx_drop
   );

   modport slave (
      output rx_data, rx_valid, tx_busy, ctrlr_busy, rd_data,
      input  tx_data, tx_start, cmd, addr, d_in, in_valid, rx_drop
   );
endinterface

// File: rtl/serial_cmd_decoder.sv
// UART-side command front end of the debugger.
// Assembles MSB-first host bytes into command / address / data words,
// issues the command to controller_fsm as a one-cycle in_valid, waits for
// the controller to go idle and serialises a 4-byte reply back to UART tx.
// Ports:
//   clk  : system clock
//   rst  : synchronous active-high reset
//   bus  : serial_cmd_decoder_if.master (rx/tx UART strobes, controller
//          command, status and rx_drop)
module serial_cmd_decoder
   import debug_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
   input  logic                 clk,
   input  logic                 rst,
   serial_cmd_decoder_if.master bus
);

   localparam int unsigned     TO_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

   state_t            r_state,    w_state_nxt;
   logic [1:0]        r_byte_cnt, w_byte_cnt_nxt;
   logic [TO_W-1:0]   r_to_cnt,   w_to_cnt_nxt;
   logic [31:0]       r_cmd_word, w_cmd_word_nxt;
   logic [31:0]       r_addr,     w_addr_nxt;
   logic [31:0]       r_d_in,     w_d_in_nxt;
   logic [31:0]       r_reply,    w_reply_nxt;
   logic              r_guard,    w_guard_nxt;
   logic              w_in_valid;
   logic              w_tx_start;
   logic              w_rx_state;
   logic              w_frame_open;
   logic [3:0]        w_cmd_code;

   assign w_cmd_code   = r_cmd_word[3:0];
   assign w_rx_state   = (r_state == S_CMD) || (r_state == S_ADDR) || (r_state == S_DATA);
   // The inter-byte timeout only runs once a frame has actually started.
   assign w_frame_open = ((r_state == S_CMD) && (r_byte_cnt != 2'd0)) ||
                         (r_state == S_ADDR) || (r_state == S_DATA);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= S_CMD;
         r_byte_cnt <= '0;
         r_to_cnt   <= '0;
         r_cmd_word <= '0;
         r_addr     <= '0;
         r_d_in     <= '0;
         r_reply    <= '0;
         r_guard    <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_byte_cnt <= w_byte_cnt_nxt;
         r_to_cnt   <= w_to_cnt_nxt;
         r_cmd_word <= w_cmd_word_nxt;
         r_addr     <= w_addr_nxt;
         r_d_in     <= w_d_in_nxt;
         r_reply    <= w_reply_nxt;
         r_guard    <= w_guard_nxt;
      end
   end

   always_comb begin
      w_state_nxt    = r_state;
      w_byte_cnt_nxt = r_byte_cnt;
      w_to_cnt_nxt   = r_to_cnt;
      w_cmd_word_nxt = r_cmd_word;
      w_addr_nxt     = r_addr;
      w_d_in_nxt     = r_d_in;
      w_reply_nxt    = r_reply;
      w_guard_nxt    = r_guard;
      w_in_valid     = 1'b0;
      w_tx_start     = 1'b0;

      // Saturating inter-byte counter; any received byte restarts it.
      if (bus.rx_valid || !w_frame_open) begin
         w_to_cnt_nxt = '0;
      end else if (r_to_cnt != TO_LAST) begin
         w_to_cnt_nxt = r_to_cnt + TO_W'(1);
      end

      case (r_state)
         S_CMD: begin
            if (bus.rx_valid) begin
               w_cmd_word_nxt = {r_cmd_word[23:0], bus.rx_data};
               w_byte_cnt_nxt = r_byte_cnt + 2'd1;
               // The byte arriving now becomes cmd_word[7:0], so decode from it.
               if (r_byte_cnt == 2'd3) begin
                  w_state_nxt = needs_addr(bus.rx_data[3:0]) ? S_ADDR : S_ISSUE;
               end
            end
         end
         S_ADDR: begin
            if (bus.rx_valid) begin
               w_addr_nxt     = {r_addr[23:0], bus.rx_data};
               w_byte_cnt_nxt = r_byte_cnt + 2'd1;
               if (r_byte_cnt == 2'd3) begin
                  w_state_nxt = needs_data(w_cmd_code) ? S_DATA : S_ISSUE;
               end
            end
         end
         S_DATA: begin
            if (bus.rx_valid) begin
               w_d_in_nxt     = {r_d_in[23:0], bus.rx_data};
               w_byte_cnt_nxt = r_byte_cnt + 2'd1;
               if (r_byte_cnt == 2'd3) begin
                  w_state_nxt = S_ISSUE;
               end
            end
         end
         S_ISSUE: begin
            if (is_valid_cmd(w_cmd_code)) begin
               w_in_valid  = 1'b1;
               w_guard_nxt = 1'b1;
               w_state_nxt = S_WAIT;
            end else begin
               w_reply_nxt = NAK_WORD;
               w_state_nxt = S_REPLY;
            end
         end
         S_WAIT: begin
            // ctrlr_busy may not have risen yet in the first wait cycle.
            if (r_guard) begin
               w_guard_nxt = 1'b0;
            end else if (!bus.ctrlr_busy) begin
               w_reply_nxt = is_read(w_cmd_code) ? bus.rd_data : r_cmd_word;
               w_state_nxt = S_REPLY;
            end
         end
         S_REPLY: begin
            if (!bus.tx_busy) begin
               w_tx_start     = 1'b1;
               w_reply_nxt    = {r_reply[23:0], 8'h00};
               w_byte_cnt_nxt = r_byte_cnt + 2'd1;
               w_guard_nxt    = 1'b1;
               w_state_nxt    = S_TXW;
            end
         end
         S_TXW: begin
            // tx_busy only rises the cycle after tx_start.
            if (r_guard) begin
               w_guard_nxt = 1'b0;
            end else if (!bus.tx_busy) begin
               w_state_nxt = (r_byte_cnt == 2'd0) ? S_CMD : S_REPLY;
            end
         end
         default: begin
            w_state_nxt = S_CMD;
         end
      endcase

      // Abort a stalled partial frame; a byte in the same cycle takes priority.
      if (w_frame_open && !bus.rx_valid && (r_to_cnt == TO_LAST)) begin
         w_state_nxt    = S_CMD;
         w_byte_cnt_nxt = '0;
         w_to_cnt_nxt   = '0;
      end
   end

   assign bus.cmd      = w_cmd_code;
   assign bus.addr     = r_addr;
   assign bus.d_in     = r_d_in;
   assign bus.in_valid = w_in_valid;
   assign bus.tx_start = w_tx_start;
   // The reply shifts left after each byte, so the next byte is always on top.
   assign bus.tx_data  = r_reply[31:24];
   assign bus.rx_drop  = bus.rx_valid && !w_rx_state;

endmodule

// File: tb/tb_serial_cmd_decoder.sv
`timescale 1ns/1ps
module tb_serial_cmd_decoder;

   localparam int T      = 16;
   localparam int TX_LEN = 5;

   typedef struct packed {
      logic [3:0]  c;
      logic [31:0] a;
      logic [31:0] d;
   } iss_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   serial_cmd_decoder_if bus ();

   serial_cmd_decoder #(.TIMEOUT_CYCLES(T)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int          n_checks = 0;
   int          n_fail   = 0;
   int          busy_len = 3;
   int          rst_gen  = 0;
   logic [31:0] m_addr   = '0;
   logic [31:0] m_din    = '0;
   iss_t        exp_iss[$];
   logic [7:0]  exp_tx[$];
   logic [7:0]  tx_log[$];
   logic [3:0]  last_cmd  = '0;
   logic [31:0] last_addr = '0;
   logic [31:0] last_din  = '0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Command classification straight from the command table.
   function automatic bit m_needs_addr(input logic [3:0] c);
      return c inside {4'h6, 4'h7, 4'h8, 4'h9, 4'hA, 4'hB, 4'hC, 4'hD};
   endfunction
   function automatic bit m_needs_data(input logic [3:0] c);
      return c inside {4'hB, 4'hC, 4'hD};
   endfunction
   function automatic bit m_is_read(input logic [3:0] c);
      return c inside {4'h5, 4'h6, 4'h7, 4'h8};
   endfunction
   function automatic bit m_valid(input logic [3:0] c);
      return !(c inside {4'h0, 4'hE, 4'hF});
   endfunction

   // Predict the issued command and the 4 reply bytes for one frame.
   task automatic expect_frame(input logic [31:0] cw, input logic [31:0] a,
                               input logic [31:0] d, input logic [31:0] rd);
      logic [3:0]  c;
      logic [31:0] reply;
      c = cw[3:0];
      if (m_needs_addr(c)) m_addr = a;
      if (m_needs_data(c)) m_din = d;
      if (m_valid(c)) begin
         exp_iss.push_back('{c: c, a: m_addr, d: m_din});
         reply = m_is_read(c) ? rd : cw;
      end else begin
         reply = 32'hFFFF_FFFF;
      end
      for (int i = 0; i < 4; i++) exp_tx.push_back(reply[31-8*i -: 8]);
      bus.rd_data = rd;
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap, input bit exp_drop);
      bus.rx_data  = b;
      bus.rx_valid = 1'b1;
      #2 check("rx_drop", 32'(bus.rx_drop), 32'(exp_drop));
      @(negedge clk);
      bus.rx_valid = 1'b0;
      repeat (gap) @(negedge clk);
   endtask

   task automatic send_word(input logic [31:0] w, input int last_gap);
      for (int i = 0; i < 4; i++) send_byte(w[31-8*i -: 8], (i == 3) ? last_gap : 1, 1'b0);
   endtask

   // Sends only the words the command needs; returns at the negedge of the
   // cycle following the final byte, where in_valid must be present.
   task automatic send_words(input logic [31:0] cw, input logic [31:0] a, input logic [31:0] d);
      logic [3:0] c;
      c = cw[3:0];
      send_word(cw, m_needs_addr(c) ? 1 : 0);
      if (m_needs_addr(c)) send_word(a, m_needs_data(c) ? 1 : 0);
      if (m_needs_data(c)) send_word(d, 0);
      check("issue_latency", 32'(bus.in_valid), 32'(m_valid(c)));
   endtask

   task automatic wait_done(input string tag);
      int k;
      k = 0;
      while ((exp_iss.size() != 0 || exp_tx.size() != 0) && k < 3000) begin
         @(negedge clk);
         k++;
      end
      repeat (2) @(negedge clk);
      while ((bus.tx_busy || bus.ctrlr_busy) && k < 3000) begin
         @(negedge clk);
         k++;
      end
      check({tag, "_completed"}, 32'(k < 3000), 32'd1);
      repeat (3) @(negedge clk);
   endtask

   task automatic send_frame(input logic [31:0] cw, input logic [31:0] a,
                             input logic [31:0] d, input logic [31:0] rd, input string tag);
      tx_log.delete();
      expect_frame(cw, a, d, rd);
      send_words(cw, a, d);
      wait_done(tag);
   endtask

   task automatic check_tx4(input string tag, input logic [31:0] w);
      check({tag, "_tx_count"}, 32'(tx_log.size()), 32'd4);
      for (int k = 0; k < 4; k++) begin
         if (k < tx_log.size())
            check($sformatf("%s_tx_byte%0d", tag, k), 32'(tx_log[k]), 32'(w[31-8*k -: 8]));
      end
   endtask

   task automatic wait_tx(input int n, input string tag);
      int k;
      k = 0;
      while (tx_log.size() < n && k < 500) begin
         @(negedge clk);
         k++;
      end
      check({tag, "_tx_seen"}, 32'(k < 500), 32'd1);
   endtask

   task automatic do_reset(input int cycles);
      rst = 1'b1;
      rst_gen++;
      exp_iss.delete();
      exp_tx.delete();
      m_addr = '0;
      m_din  = '0;
      repeat (cycles) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_in_valid"}, 32'(bus.in_valid), 32'd0);
      check({tag, "_tx_start"}, 32'(bus.tx_start), 32'd0);
      check({tag, "_rx_drop"},  32'(bus.rx_drop),  32'd0);
      check({tag, "_cmd"},      32'(bus.cmd),      32'd0);
      check({tag, "_addr"},     bus.addr,          32'd0);
      check({tag, "_d_in"},     bus.d_in,          32'd0);
      check({tag, "_tx_data"},  32'(bus.tx_data),  32'd0);
   endtask

   // Controller stand-in: busy from the in_valid cycle for busy_len cycles.
   initial begin : ctrl_model
      bus.ctrlr_busy = 1'b0;
      forever begin
         @(negedge clk);
         if (bus.in_valid) begin
            bus.ctrlr_busy = 1'b1;
            repeat (busy_len) @(negedge clk);
            bus.ctrlr_busy = 1'b0;
         end
      end
   end

   // UART tx stand-in: busy rises the cycle after tx_start.
   initial begin : uart_tx_model
      bus.tx_busy = 1'b0;
      forever begin
         @(negedge clk);
         if (bus.tx_start) begin
            tx_log.push_back(bus.tx_data);
            @(posedge clk);
            #1 bus.tx_busy = 1'b1;
            repeat (TX_LEN) @(posedge clk);
            #1 bus.tx_busy = 1'b0;
         end
      end
   end

   // Per-cycle comparison of issued commands and transmitted bytes.
   initial begin : compare
      int   seen_gen;
      bit   hold;
      iss_t held;
      iss_t e;
      seen_gen = 0;
      hold     = 1'b0;
      held     = '0;
      forever begin
         @(negedge clk);
         if (rst_gen != seen_gen) begin
            seen_gen = rst_gen;
            hold     = 1'b0;
         end
         if (bus.in_valid) begin
            last_cmd  = bus.cmd;
            last_addr = bus.addr;
            last_din  = bus.d_in;
            n_checks++;
            if (exp_iss.size() == 0) begin
               n_fail++;
               $display("FAIL unexpected_in_valid: got cmd %h, required no issue", bus.cmd);
            end else begin
               n_checks--;
               e = exp_iss.pop_front();
               check("issue_cmd",  32'(bus.cmd), 32'(e.c));
               check("issue_addr", bus.addr,     e.a);
               check("issue_d_in", bus.d_in,     e.d);
               held = e;
               hold = 1'b1;
            end
         end else if (hold) begin
            if (bus.ctrlr_busy) begin
               check("hold_cmd",  32'(bus.cmd), 32'(held.c));
               check("hold_addr", bus.addr,     held.a);
               check("hold_d_in", bus.d_in,     held.d);
            end else begin
               hold = 1'b0;
            end
         end
         if (bus.tx_start) begin
            n_checks++;
            if (exp_tx.size() == 0) begin
               n_fail++;
               $display("FAIL unexpected_tx_start: got byte %h, required no transmit", bus.tx_data);
            end else begin
               n_checks--;
               check("tx_byte", 32'(bus.tx_data), 32'(exp_tx.pop_front()));
            end
         end
      end
   end

   initial begin : watchdog
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   initial begin : stim
      logic [3:0]  mc [3];
      logic [31:0] ma [3];
      logic [31:0] md [3];
      logic [31:0] mr [3];
      logic [31:0] bad [2];
      rst          = 1'b1;
      bus.rx_data  = '0;
      bus.rx_valid = 1'b0;
      bus.rd_data  = '0;

      do_reset(3);
      check_zero("reset");

      // Pause: no address, reply echoes the command word.
      busy_len = 3;
      send_frame(32'h0000_0001, 32'h0, 32'h0, 32'h0, "pause");
      check_tx4("pause", 32'h0000_0001);
      check("pause_cmd", 32'(last_cmd), 32'h1);

      // Word read: address word, reply is rd_data.
      send_frame(32'h0000_0007, 32'h0000_1000, 32'h0, 32'hDEAD_BEEF, "mem_rd");
      check_tx4("mem_rd", 32'hDEAD_BEEF);
      check("mem_rd_addr", last_addr, 32'h0000_1000);

      // Register write: address and data words, reply echoes command.
      send_frame(32'h0000_000D, 32'h0000_0005, 32'h1234_5678, 32'h0, "reg_wr");
      check_tx4("reg_wr", 32'h0000_000D);
      check("reg_wr_addr", last_addr, 32'h0000_0005);
      check("reg_wr_d_in", last_din,  32'h1234_5678);

      // Further mixes: memory write, status read, breakpoint set.
      mc = '{4'hB, 4'h5, 4'h9};
      ma = '{32'h0000_0020, 32'h0, 32'h0000_0002};
      md = '{32'hCAFE_F00D, 32'h0, 32'h0};
      mr = '{32'h0, 32'hA5A5_0001, 32'h5555_AAAA};
      for (int i = 0; i < 3; i++) begin
         busy_len = 1 + 2 * i;
         send_frame({28'h000_0000, mc[i]}, ma[i], md[i], mr[i], $sformatf("mix%0d", i));
      end

      // Timeout: two bytes then T idle cycles abandon the frame.
      busy_len = 3;
      send_byte(8'h00, 1, 1'b0);
      send_byte(8'h00, T, 1'b0);
      send_frame(32'h0000_0002, 32'h0, 32'h0, 32'h0, "after_timeout");
      check_tx4("after_timeout", 32'h0000_0002);

      // A byte landing in the last counted cycle is still accepted.
      tx_log.delete();
      expect_frame(32'h0000_0003, 32'h0, 32'h0, 32'h0);
      send_byte(8'h00, 1, 1'b0);
      send_byte(8'h00, T - 1, 1'b0);
      send_byte(8'h00, 1, 1'b0);
      send_byte(8'h03, 0, 1'b0);
      check("byte_wins_in_valid", 32'(bus.in_valid), 32'd1);
      wait_done("byte_wins");
      check_tx4("byte_wins", 32'h0000_0003);

      // Invalid command F: NAK, and a byte during the reply is dropped.
      tx_log.delete();
      expect_frame(32'h0000_000F, 32'h0, 32'h0, 32'h0);
      send_words(32'h0000_000F, 32'h0, 32'h0);
      wait_tx(1, "nak_f");
      send_byte(8'hAA, 0, 1'b1);
      wait_done("nak_f");
      check_tx4("nak_f", 32'hFFFF_FFFF);

      bad = '{32'h0000_000E, 32'h0000_0000};
      for (int i = 0; i < 2; i++) begin
         send_frame(bad[i], 32'h0, 32'h0, 32'h0, $sformatf("nak%0d", i));
         check_tx4($sformatf("nak%0d", i), 32'hFFFF_FFFF);
      end

      // Reset while waiting on the controller.
      busy_len = 30;
      tx_log.delete();
      expect_frame(32'h0000_0005, 32'h0, 32'h0, 32'h0BAD_0BAD);
      send_words(32'h0000_0005, 32'h0, 32'h0);
      repeat (2) @(negedge clk);
      do_reset(1);
      check_zero("rst_wait");
      wait_done("rst_wait_settle");
      busy_len = 3;
      send_frame(32'h0000_0001, 32'h0, 32'h0, 32'h0, "post_rst_wait");
      check_tx4("post_rst_wait", 32'h0000_0001);

      // Reset in the middle of the reply.
      tx_log.delete();
      expect_frame(32'h0000_0007, 32'h0000_0044, 32'h0, 32'h1122_3344);
      send_words(32'h0000_0007, 32'h0000_0044, 32'h0);
      wait_tx(2, "rst_txw");
      do_reset(1);
      check_zero("rst_txw");
      wait_done("rst_txw_settle");
      send_frame(32'h0000_000D, 32'h0000_0009, 32'hA0B0_C0D0, 32'h0, "post_rst_txw");
      check_tx4("post_rst_txw", 32'h0000_000D);
      check("post_rst_txw_addr", last_addr, 32'h0000_0009);
      check("post_rst_txw_d_in", last_din,  32'hA0B0_C0D0);

      check("leftover_issues", 32'(exp_iss.size()), 32'd0);
      check("leftover_tx",     32'(exp_tx.size()),  32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
